// File: rtl/ysyx_25040105_mc_core.sv
// Multi-cycle RV32I-subset core (FETCH/DECODE/EXEC/WB) with a fetch handshake,
// a fetch watchdog, an RV32E option, a debug register read port and registered halt status.
module ysyx_25040105_mc_core #(
   parameter int          NREG          = 32,
   parameter logic [31:0] RESET_PC      = 32'h8000_0000,
   parameter int          FETCH_TIMEOUT = 255,
   parameter int          TO_W          = 8
) (
   input  logic                    clk,
   input  logic                    rst,
   output logic                    imem_req,
   output logic [31:0]             imem_addr,
   input  logic                    imem_rvalid,
   input  logic [31:0]             imem_rdata,
   output logic [31:0]             pc,
   output logic                    retire,
   output logic [31:0]             retire_pc,
   output logic                    halted,
   output logic [1:0]              halt_code,
   input  logic [$clog2(NREG)-1:0] dbg_raddr,
   output logic [31:0]             dbg_rdata
);

   localparam int RW = $clog2(NREG);
   localparam logic [TO_W-1:0] WDOG_LAST = TO_W'((FETCH_TIMEOUT > 0) ? FETCH_TIMEOUT - 1 : 0);
   localparam logic [31:0] EBREAK = 32'h0010_0073;

   typedef enum logic [2:0] {S_FETCH, S_DECODE, S_EXEC, S_WB, S_HALT} state_t;
   typedef enum logic [3:0] {
      OP_ADD, OP_SUB, OP_ADDI, OP_LUI, OP_AUIPC, OP_JAL, OP_JALR, OP_EBREAK, OP_ILL
   } op_t;

   state_t          state_q;
   op_t             op_q;
   logic [31:0]     pc_q;
   logic [31:0]     ir_q;
   logic [TO_W-1:0] wdog_q;
   logic [31:0]     regs_q [NREG];
   logic [4:0]      rd_q;
   logic [31:0]     rs1Val_q;
   logic [31:0]     rs2Val_q;
   logic [31:0]     imm_q;
   logic            a0NonZero_q;
   logic [31:0]     result_q;
   logic [31:0]     nextPc_q;
   logic            retire_q;
   logic [31:0]     retirePc_q;
   logic            halted_q;
   logic [1:0]      haltCode_q;

   logic [6:0]  opcode;
   logic [2:0]  funct3;
   logic [6:0]  funct7;
   logic [4:0]  rs1Idx;
   logic [4:0]  rs2Idx;
   logic [4:0]  rdIdx;
   logic [31:0] immI;
   logic [31:0] immU;
   logic [31:0] immJ;

   assign opcode = ir_q[6:0];
   assign rdIdx  = ir_q[11:7];
   assign funct3 = ir_q[14:12];
   assign rs1Idx = ir_q[19:15];
   assign rs2Idx = ir_q[24:20];
   assign funct7 = ir_q[31:25];
   assign immI   = {{20{ir_q[31]}}, ir_q[31:20]};
   assign immU   = {ir_q[31:12], 12'b0};
   assign immJ   = {{12{ir_q[31]}}, ir_q[19:12], ir_q[20], ir_q[30:21], 1'b0};

   op_t         op_d;
   logic [31:0] imm_d;
   logic        useRs1_d;
   logic        useRs2_d;
   logic        useRd_d;
   logic        badIdx_d;
   logic [31:0] rs1Val_d;
   logic [31:0] rs2Val_d;

   // Decode also records which register fields the instruction actually uses, so
   // the RV32E build can reject only genuinely referenced upper registers.
   always_comb begin
      op_d     = OP_ILL;
      imm_d    = '0;
      useRs1_d = 1'b0;
      useRs2_d = 1'b0;
      useRd_d  = 1'b0;
      case (opcode)
         7'b0110011: begin
            if (funct3 == 3'b000 && funct7 == 7'b0000000) op_d = OP_ADD;
            else if (funct3 == 3'b000 && funct7 == 7'b0100000) op_d = OP_SUB;
            useRs1_d = 1'b1;
            useRs2_d = 1'b1;
            useRd_d  = 1'b1;
         end
         7'b0010011: begin
            if (funct3 == 3'b000) op_d = OP_ADDI;
            imm_d    = immI;
            useRs1_d = 1'b1;
            useRd_d  = 1'b1;
         end
         7'b0110111: begin
            op_d    = OP_LUI;
            imm_d   = immU;
            useRd_d = 1'b1;
         end
         7'b0010111: begin
            op_d    = OP_AUIPC;
            imm_d   = immU;
            useRd_d = 1'b1;
         end
         7'b1101111: begin
            op_d    = OP_JAL;
            imm_d   = immJ;
            useRd_d = 1'b1;
         end
         7'b1100111: begin
            if (funct3 == 3'b000) op_d = OP_JALR;
            imm_d    = immI;
            useRs1_d = 1'b1;
            useRd_d  = 1'b1;
         end
         default: ;
      endcase
      if (ir_q == EBREAK) begin
         op_d     = OP_EBREAK;
         useRs1_d = 1'b0;
         useRs2_d = 1'b0;
         useRd_d  = 1'b0;
      end
      badIdx_d = (NREG < 32) &&
                 ((useRs1_d && rs1Idx[4]) || (useRs2_d && rs2Idx[4]) || (useRd_d && rdIdx[4]));
   end

   assign rs1Val_d = (rs1Idx == 5'd0) ? 32'd0 : regs_q[rs1Idx[RW-1:0]];
   assign rs2Val_d = (rs2Idx == 5'd0) ? 32'd0 : regs_q[rs2Idx[RW-1:0]];

   logic [31:0] result_d;
   logic [31:0] nextPc_d;

   always_comb begin
      result_d = '0;
      nextPc_d = pc_q + 32'd4;
      case (op_q)
         OP_ADD:    result_d = rs1Val_q + rs2Val_q;
         OP_SUB:    result_d = rs1Val_q - rs2Val_q;
         OP_ADDI:   result_d = rs1Val_q + imm_q;
         OP_LUI:    result_d = imm_q;
         OP_AUIPC:  result_d = pc_q + imm_q;
         OP_JAL: begin
            result_d = pc_q + 32'd4;
            nextPc_d = pc_q + imm_q;
         end
         OP_JALR: begin
            result_d = pc_q + 32'd4;
            nextPc_d = (rs1Val_q + imm_q) & ~32'd1;
         end
         OP_EBREAK: nextPc_d = pc_q;
         default: ;
      endcase
   end

   // Main FSM; every externally visible status bit is a register updated here.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q     <= S_FETCH;
         op_q        <= OP_ILL;
         pc_q        <= RESET_PC;
         ir_q        <= '0;
         wdog_q      <= '0;
         rd_q        <= '0;
         rs1Val_q    <= '0;
         rs2Val_q    <= '0;
         imm_q       <= '0;
         a0NonZero_q <= 1'b0;
         result_q    <= '0;
         nextPc_q    <= '0;
         retire_q    <= 1'b0;
         retirePc_q  <= '0;
         halted_q    <= 1'b0;
         haltCode_q  <= 2'd0;
         for (int i = 0; i < NREG; i++) regs_q[i] <= '0;
      end else begin
         retire_q <= 1'b0;
         case (state_q)
            S_FETCH: begin
               if (imem_rvalid) begin
                  ir_q    <= imem_rdata;
                  wdog_q  <= '0;
                  state_q <= S_DECODE;
               end else if ((FETCH_TIMEOUT > 0) && (wdog_q == WDOG_LAST)) begin
                  state_q    <= S_HALT;
                  halted_q   <= 1'b1;
                  haltCode_q <= 2'd2;
               end else begin
                  wdog_q <= wdog_q + 1'b1;
               end
            end
            S_DECODE: begin
               if (op_d == OP_ILL || badIdx_d) begin
                  state_q    <= S_HALT;
                  halted_q   <= 1'b1;
                  haltCode_q <= 2'd3;
               end else begin
                  op_q        <= op_d;
                  rd_q        <= rdIdx;
                  rs1Val_q    <= rs1Val_d;
                  rs2Val_q    <= rs2Val_d;
                  imm_q       <= imm_d;
                  a0NonZero_q <= (regs_q[10] != 32'd0);
                  state_q     <= S_EXEC;
               end
            end
            S_EXEC: begin
               if (nextPc_d[1]) begin
                  state_q    <= S_HALT;
                  halted_q   <= 1'b1;
                  haltCode_q <= 2'd3;
               end else begin
                  result_q   <= result_d;
                  nextPc_q   <= nextPc_d;
                  retire_q   <= 1'b1;
                  retirePc_q <= pc_q;
                  state_q    <= S_WB;
               end
            end
            S_WB: begin
               pc_q <= nextPc_q;
               if (op_q == OP_EBREAK) begin
                  state_q    <= S_HALT;
                  halted_q   <= 1'b1;
                  haltCode_q <= {1'b0, a0NonZero_q};
               end else begin
                  if (rd_q != 5'd0) regs_q[rd_q[RW-1:0]] <= result_q;
                  state_q <= S_FETCH;
               end
            end
            default: ;
         endcase
      end
   end

   assign imem_req  = (state_q == S_FETCH);
   assign imem_addr = pc_q;
   assign pc        = pc_q;
   assign retire    = retire_q;
   assign retire_pc = retirePc_q;
   assign halted    = halted_q;
   assign halt_code = haltCode_q;
   assign dbg_rdata = (dbg_raddr == '0) ? 32'd0 : regs_q[dbg_raddr];

endmodule
